// File: rtl/uart_pkg.sv
// Shared UART receiver types and defaults: FSM state encoding, default frame
// geometry and the even-parity check helper.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MAX_BITS   = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_mismatch(input logic [UART_MAX_BITS-1:0] bits,
                                           input logic                     par_bit);
    return (^bits) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: baud tick and serial line in, received word and status out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic                 tick;
  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output tick, rxd, input data, valid, frame_err, parity_err, busy);
  modport slave  (input tick, rxd, output data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Metastability filter: the second stage is the only one consumers may see.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DATA_BITS LSB-first, optional even parity, stop).
// Define UART_RX_PARITY_EN to add the parity bit and parity_err checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic                 rxd_s;
  rx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r;
  logic                 parity_err_r;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rxd),
    .q   (rxd_s)
  );

  // Receive FSM: every decision is taken on a tick; valid is cleared on every other clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      data_r       <= {DATA_BITS{1'b0}};
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      if (bus.tick) begin
        case (state_r)
          IDLE: begin
            cnt_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            if (!rxd_s) begin
              state_r <= START;
              busy_r  <= 1'b1;
            end else begin
              busy_r  <= 1'b0;
            end
          end
          START: begin
            if (cnt_r == HALF_M1) begin
              cnt_r <= {CNT_W{1'b0}};
              if (rxd_s) begin
                // Line went back high before mid-bit: treat as a glitch.
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= DATA;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          DATA: begin
            if (cnt_r == FULL_M1) begin
              cnt_r   <= {CNT_W{1'b0}};
              shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
              if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                state_r   <= PARITY;
`else
                state_r   <= STOP;
`endif
              end else begin
                bit_cnt_r <= bit_cnt_r + BIT_ONE;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt_r == FULL_M1) begin
              cnt_r     <= {CNT_W{1'b0}};
              par_bad_r <= parity_mismatch(UART_MAX_BITS'(shift_r), rxd_s);
              state_r   <= STOP;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
`endif
          STOP: begin
            if (cnt_r == FULL_M1) begin
              cnt_r        <= {CNT_W{1'b0}};
              data_r       <= shift_r;
              frame_err_r  <= ~rxd_s;
`ifdef UART_RX_PARITY_EN
              parity_err_r <= par_bad_r;
`endif
              valid_r      <= 1'b1;
              state_r      <= IDLE;
              busy_r       <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
